// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync/DE decode, pixel coordinates, linear address, line/frame strobes.
// Optional colour-bar test pattern on RGB when VGA_TIMING_TPG_EN is defined; otherwise RGB is tied to 0.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11,
  parameter int unsigned AW       = 19
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  output logic          HS,
  output logic          VS,
  output logic          DE,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic [AW-1:0] ADDR,
  output logic          SOL,
  output logic          SOF,
  output logic [23:0]   RGB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_LST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_LST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [AW-1:0] addr;
  logic          de;
  logic          hs_act;
  logic          vs_act;
  logic          line_end;

  always_comb begin
    de       = (hc < H_ACT) && (vc < V_ACT);
    hs_act   = (hc >= H_SYNC_BEG) && (hc <= H_SYNC_LST);
    vs_act   = (vc >= V_SYNC_BEG) && (vc <= V_SYNC_LST);
    line_end = (hc == H_LAST);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hc <= '0;
      vc <= '0;
    end else if (EN) begin
      if (line_end) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
      end else begin
        hc <= hc + CW'(1);
      end
    end
  end

  // Restarts after the final visible pixel so it is already 0 when the next frame's DE begins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr <= '0;
    end else if (EN && de) begin
      if (hc == H_ACT_LAST && vc == V_ACT_LAST) addr <= '0;
      else                                      addr <= addr + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      HS   <= ~HS_POL;
      VS   <= ~VS_POL;
      DE   <= 1'b0;
      X    <= '0;
      Y    <= '0;
      ADDR <= '0;
      SOL  <= 1'b0;
      SOF  <= 1'b0;
    end else if (EN) begin
      HS   <= hs_act ? HS_POL : ~HS_POL;
      VS   <= vs_act ? VS_POL : ~VS_POL;
      DE   <= de;
      ADDR <= addr;
      SOL  <= de && (hc == '0);
      SOF  <= de && (hc == '0) && (vc == '0);
      if (de) begin
        X <= hc;
        Y <= vc;
      end
    end
  end

`ifdef VGA_TIMING_TPG_EN
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

  logic [CW-1:0] bar_cnt;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb;

  // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
  always_comb begin
    bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (EN) begin
      if (line_end) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  RGB <= '0;
    else if (EN) RGB <= de ? bar_rgb : '0;
  end
`else
  assign RGB = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing on one instance, a tiny
// positive-polarity configuration on a second instance for frame-level behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_TPG_EN
  localparam bit TPG = 1'b1;
`else
  localparam bit TPG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_d = 1'b0;
  logic en_s = 1'b0;

  logic        d_hs, d_vs, d_de, d_sol, d_sof;
  logic [10:0] d_x, d_y;
  logic [18:0] d_addr;
  logic [23:0] d_rgb;

  logic        s_hs, s_vs, s_de, s_sol, s_sof;
  logic [3:0]  s_x, s_y, s_addr;
  logic [23:0] s_rgb;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .CLK(clk), .RST_N(rst_n), .EN(en_d),
    .HS(d_hs), .VS(d_vs), .DE(d_de), .X(d_x), .Y(d_y), .ADDR(d_addr),
    .SOL(d_sol), .SOF(d_sof), .RGB(d_rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .AW(4)
  ) u_small (
    .CLK(clk), .RST_N(rst_n), .EN(en_s),
    .HS(s_hs), .VS(s_vs), .DE(s_de), .X(s_x), .Y(s_y), .ADDR(s_addr),
    .SOL(s_sol), .SOF(s_sof), .RGB(s_rgb)
  );

  typedef struct {
    int unsigned n;
    logic        de;
    int unsigned x;
    int unsigned y;
    int unsigned addr;
    logic        sol;
    logic        sof;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_def_reset(input string tag);
    chk({tag, ".de"},   32'(d_de),   32'd0);
    chk({tag, ".x"},    32'(d_x),    32'd0);
    chk({tag, ".y"},    32'(d_y),    32'd0);
    chk({tag, ".addr"}, 32'(d_addr), 32'd0);
    chk({tag, ".sol"},  32'(d_sol),  32'd0);
    chk({tag, ".sof"},  32'(d_sof),  32'd0);
    chk({tag, ".hs"},   32'(d_hs),   32'd1);
    chk({tag, ".vs"},   32'(d_vs),   32'd1);
    chk({tag, ".rgb"},  32'(d_rgb),  32'd0);
  endtask

  initial begin
    int unsigned n;
    int unsigned hs_low, de_cnt, sol_cnt, cnt;
    int unsigned sof_s, vs_s, hs_s;

    //         n     de  x    y  addr  sol sof hs vs rgb
    tbl[0]  = '{1,    1,  0,   0, 0,    1,  1,  1, 1, 24'hFFFFFF};
    tbl[1]  = '{2,    1,  1,   0, 1,    0,  0,  1, 1, 24'hFFFFFF};
    tbl[2]  = '{80,   1,  79,  0, 79,   0,  0,  1, 1, 24'hFFFFFF};
    tbl[3]  = '{81,   1,  80,  0, 80,   0,  0,  1, 1, 24'hFFFF00};
    tbl[4]  = '{561,  1,  560, 0, 560,  0,  0,  1, 1, 24'h000000};
    tbl[5]  = '{640,  1,  639, 0, 639,  0,  0,  1, 1, 24'h000000};
    tbl[6]  = '{641,  0,  639, 0, 0,    0,  0,  1, 1, 24'h000000};
    tbl[7]  = '{656,  0,  639, 0, 0,    0,  0,  1, 1, 24'h000000};
    tbl[8]  = '{657,  0,  639, 0, 0,    0,  0,  0, 1, 24'h000000};
    tbl[9]  = '{752,  0,  639, 0, 0,    0,  0,  0, 1, 24'h000000};
    tbl[10] = '{753,  0,  639, 0, 0,    0,  0,  1, 1, 24'h000000};
    tbl[11] = '{800,  0,  639, 0, 0,    0,  0,  1, 1, 24'h000000};
    tbl[12] = '{801,  1,  0,   1, 640,  1,  0,  1, 1, 24'hFFFFFF};
    tbl[13] = '{802,  1,  1,   1, 641,  0,  0,  1, 1, 24'hFFFFFF};
    tbl[14] = '{901,  1,  100, 1, 740,  0,  0,  1, 1, 24'hFFFF00};
    tbl[15] = '{1601, 1,  0,   2, 1280, 1,  0,  1, 1, 24'hFFFFFF};

    // Reset state on both instances
    repeat (3) tick();
    chk_def_reset("rst");
    chk("rst.s_hs", 32'(s_hs), 32'd0);
    chk("rst.s_vs", 32'(s_vs), 32'd0);
    chk("rst.s_de", 32'(s_de), 32'd0);

    // Default timing, table driven
    rst_n = 1'b1;
    en_d  = 1'b1;
    n = 0; hs_low = 0; de_cnt = 0; sol_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while (n < tbl[i].n) begin
        tick();
        n++;
        if (n <= 800) begin
          hs_low += (d_hs == 1'b0) ? 1 : 0;
          de_cnt += d_de ? 1 : 0;
        end
        sol_cnt += d_sol ? 1 : 0;
      end
      chk($sformatf("v%0d.de", i),  32'(d_de),  32'(tbl[i].de));
      chk($sformatf("v%0d.x", i),   32'(d_x),   tbl[i].x);
      chk($sformatf("v%0d.y", i),   32'(d_y),   tbl[i].y);
      if (tbl[i].de)
        chk($sformatf("v%0d.addr", i), 32'(d_addr), tbl[i].addr);
      chk($sformatf("v%0d.sol", i), 32'(d_sol), 32'(tbl[i].sol));
      chk($sformatf("v%0d.sof", i), 32'(d_sof), 32'(tbl[i].sof));
      chk($sformatf("v%0d.hs", i),  32'(d_hs),  32'(tbl[i].hs));
      chk($sformatf("v%0d.vs", i),  32'(d_vs),  32'(tbl[i].vs));
      chk($sformatf("v%0d.rgb", i), 32'(d_rgb), TPG ? 32'(tbl[i].rgb) : 32'd0);
    end
    chk("line0.hs_low_cycles", hs_low, 32'd96);
    chk("line0.de_cycles", de_cnt, 32'd640);
    chk("sol_pulses_1601", sol_cnt, 32'd3);

    // Stall mid-line at X=100 of line 2
    repeat (100) tick();
    chk("pre_stall.x", 32'(d_x), 32'd100);
    chk("pre_stall.addr", 32'(d_addr), 32'd1380);
    en_d = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d.x", k),    32'(d_x),    32'd100);
      chk($sformatf("stall%0d.addr", k), 32'(d_addr), 32'd1380);
      chk($sformatf("stall%0d.de", k),   32'(d_de),   32'd1);
    end
    en_d = 1'b1;
    tick();
    chk("resume.x", 32'(d_x), 32'd101);
    chk("resume.addr", 32'(d_addr), 32'd1381);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!d_sol && cnt < 2000);
    chk("resume.edges_to_sol", cnt, 32'd699);
    chk("line3.x", 32'(d_x), 32'd0);
    chk("line3.y", 32'(d_y), 32'd3);
    chk("line3.addr", 32'(d_addr), 32'd1920);
    chk("line3.sof", 32'(d_sof), 32'd0);

    // SOL pulse stretches across a stall
    en_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("sol_stall%0d.sol", k), 32'(d_sol), 32'd1);
      chk($sformatf("sol_stall%0d.x", k),   32'(d_x),   32'd0);
    end
    en_d = 1'b1;
    tick();
    chk("sol_resume.sol", 32'(d_sol), 32'd0);
    chk("sol_resume.x", 32'(d_x), 32'd1);
    chk("sol_resume.addr", 32'(d_addr), 32'd1921);

    // Asynchronous reset mid-line
    repeat (299) tick();
    chk("pre_rst.x", 32'(d_x), 32'd300);
    chk("pre_rst.y", 32'(d_y), 32'd3);
    chk("pre_rst.addr", 32'(d_addr), 32'd2220);
    #2;
    rst_n = 1'b0;
    #1;
    chk_def_reset("arst");
    repeat (3) tick();
    chk_def_reset("arst_hold");
    rst_n = 1'b1;
    tick();
    chk("post_rst.de", 32'(d_de), 32'd1);
    chk("post_rst.x", 32'(d_x), 32'd0);
    chk("post_rst.y", 32'(d_y), 32'd0);
    chk("post_rst.addr", 32'(d_addr), 32'd0);
    chk("post_rst.sol", 32'(d_sol), 32'd1);
    chk("post_rst.sof", 32'(d_sof), 32'd1);

    // Small configuration: two full frames of 42 clocks each
    en_d = 1'b0;
    en_s = 1'b1;
    sof_s = 0; vs_s = 0; hs_s = 0;
    for (int unsigned m = 1; m <= 84; m++) begin
      int unsigned h, v;
      logic de_e;
      tick();
      h = (m - 1) % 7;
      v = ((m - 1) / 7) % 6;
      de_e = (h < 4) && (v < 3);
      chk($sformatf("s%0d.de", m),  32'(s_de),  32'(de_e));
      chk($sformatf("s%0d.sol", m), 32'(s_sol), 32'(de_e && h == 0));
      chk($sformatf("s%0d.sof", m), 32'(s_sof), 32'(de_e && h == 0 && v == 0));
      chk($sformatf("s%0d.hs", m),  32'(s_hs),  32'(h == 5));
      chk($sformatf("s%0d.vs", m),  32'(s_vs),  32'(v == 4));
      if (de_e) begin
        chk($sformatf("s%0d.x", m),    32'(s_x),    h);
        chk($sformatf("s%0d.y", m),    32'(s_y),    v);
        chk($sformatf("s%0d.addr", m), 32'(s_addr), v * 4 + h);
      end
      sof_s += s_sof ? 1 : 0;
      vs_s  += s_vs  ? 1 : 0;
      hs_s  += s_hs  ? 1 : 0;
    end
    chk("small.sof_count", sof_s, 32'd2);
    chk("small.vs_high", vs_s, 32'd14);
    chk("small.hs_high", hs_s, 32'd12);
    chk("frozen.def_x", 32'(d_x), 32'd0);
    chk("frozen.def_sof", 32'(d_sof), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates HS, VS and data-enable (DE) from fully parametrised horizontal and vertical timing, with selectable sync polarity and a pixel-clock enable for stalling.
- Outputs pixel X/Y coordinates and a linear frame-buffer address, plus start-of-line and start-of-frame strobes.
- Sits between the pixel clock domain and the frame-buffer read port / DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line (must be a multiple of 8)
- H_FP, 16, horizontal front porch, clocks
- H_SYNC, 96, horizontal sync width, clocks
- H_BP, 48, horizontal back porch, clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- HS_POL, 0, active level of HS (0 = active-low)
- VS_POL, 0, active level of VS (0 = active-low)
- CW, 11, width of H/V counters and X/Y outputs (must hold H_TOTAL-1 and V_TOTAL-1)
- AW, 19, address width (must hold H_ACTIVE*V_ACTIVE-1)

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  pixel-clock enable; low freezes all state
- HS  out  1  horizontal sync, registered
- VS  out  1  vertical sync, registered
- DE  out  1  active-video enable, registered
- X  out  CW  pixel column, valid when DE=1
- Y  out  CW  pixel row, valid when DE=1
- ADDR  out  AW  linear pixel address, Y*H_ACTIVE+X, valid when DE=1
- SOL  out  1  one-cycle pulse with the first active pixel of each line
- SOF  out  1  one-cycle pulse with pixel (0,0) of each frame
- RGB  out  24  test-pattern colour {R[7:0],G[7:0],B[7:0]}

Behaviour:
- Reset:
  - Clock and reset: one clock CLK; reset RST_N is asynchronous and active-low.
  - While RST_N=0: internal hc=0, vc=0, addr counter=0.
  - Outputs in reset: DE=0, SOL=0, SOF=0, X=0, Y=0, ADDR=0, RGB=0.
  - Sync outputs in reset: HS=~HS_POL, VS=~VS_POL (inactive).
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters, on each CLK edge with EN=1:
  - hc increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, vc increments and wraps from V_TOTAL-1 to 0 (both wrap together at frame end).
- Decode, combinational from current hc/vc:
  - de = hc<H_ACTIVE && vc<V_ACTIVE
  - hs_act = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC
- Output registers: on each EN=1 edge, all outputs register the decode of the pre-increment hc/vc.
  - Latency: outputs lag the counters by exactly 1 enabled clock.
  - HS = hs_act ? HS_POL : ~HS_POL; VS likewise with VS_POL.
  - X=hc and Y=vc when de, else hold the previous value.
  - SOL = de && hc==0; SOF = de && hc==0 && vc==0.
- Address counter:
  - Increments by 1 on each enabled edge with de=1.
  - Reset to 0 after the last active pixel (hc=H_ACTIVE-1, vc=V_ACTIVE-1).
  - ADDR registers the pre-increment value, so ADDR == Y*H_ACTIVE+X whenever DE=1.
- EN=0: counters and all output registers hold, including SOL/SOF (a pulse stretches across stall cycles).
- First enabled edge after reset release: DE=1, X=0, Y=0, ADDR=0, SOL=1, SOF=1.
- Reset mid-frame: immediate asynchronous return to reset values; the frame restarts at (0,0).
- Widths: all compares are unsigned at CW bits; the address is AW bits; no truncation is permitted within legal parameter ranges.

Optional Feature:
- Macro: VGA_TIMING_TPG_EN.
- Defined: RGB carries 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Colour order from X=0: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF or 8'h00).
  - Bar index comes from a bar counter reset at each line start; no divider.
  - RGB is registered alongside DE and forced to 0 when DE=0.
- Undefined: RGB is constant 0 and no bar logic is synthesised.

Test Plan:
- Reset, then release with EN=1, defaults -> first edge: DE=1, X=0, Y=0, ADDR=0, SOL=1, SOF=1, HS=1, VS=1.
- Defaults, run one line -> DE high for 640 clocks (X 0..639); HS low for exactly 96 clocks, starting on output cycle 656 of the line; SOL pulses once per 800 clocks.
- Small params (H 4/1/1/1, V 3/1/1/1, HS_POL=VS_POL=1), run 2 frames -> ADDR 0..11 then wraps to 0; SOF every 42 clocks; VS high for exactly 7 clocks per frame.
- Toggle EN low for 5 clocks mid-line at X=100 -> all outputs frozen for 5 clocks; on resume X=101, ADDR+1; line length is unchanged in enabled clocks.
- Assert RST_N at X=300, Y=200 for 3 clocks -> outputs take reset values asynchronously; after release the next enabled edge gives X=0, Y=0, SOF=1.
- With VGA_TIMING_TPG_EN, defaults -> X=0..79 gives RGB=FFFFFF; X=80 gives FFFF00; X=560..639 gives 000000; blanking gives RGB=0.
